divider_8by4u: RTL and testbench

DIVIDER_8BY4U -- requirements
Module: divider_8by4u

---
 rtl/divider_8by4u_pkg.sv | 14 +
 rtl/divider_8by4u_div_step.sv | 28 ++
 rtl/divider_8by4u.sv | 118 +++++++++++
 tb/tb_divider_8by4u.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/divider_8by4u_pkg.sv
// Shared definitions for the 8-by-4 unsigned restoring divider:
// default widths and the FSM state encoding.
package divider_8by4u_pkg;

  localparam int DEF_N = 8;
  localparam int DEF_M = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider_8by4u_div_step.sv
// One restoring-division step: shift the partial remainder left, bring in a
// dividend bit, and keep the difference only when it is non-negative.
module div_step #(
  parameter int M = 4
) (
  input  logic [M:0]   rem_in,
  input  logic         din,
  input  logic [M-1:0] divisor,
  output logic [M:0]   rem_out,
  output logic         qbit
);

  logic [M+1:0] shifted;
  logic [M+1:0] divisor_ext;

  always_comb begin
    shifted     = {rem_in, din};
    divisor_ext = {2'b00, divisor};
    qbit        = (shifted >= divisor_ext);
    // The remainder never reaches the divisor, so M+1 bits always hold the result.
    if (qbit) begin
      rem_out = (M+1)'(shifted - divisor_ext);
    end else begin
      rem_out = (M+1)'(shifted);
    end
  end

endmodule

// File: rtl/divider_8by4u.sv
// Multi-cycle unsigned divider (N-bit dividend, M-bit divisor), one restoring
// step per cycle, with divide-by-zero detection and back-to-back starts via DONE.
module divider_8by4u
  import divider_8by4u_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [M-1:0] b,
  output logic         ready,
  output logic [N-1:0] q,
  output logic [M-1:0] r,
  output logic         valid,
  output logic         dbz
);

  localparam int            CW   = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [N-1:0]  work;      // dividend bits shift out MSB-first, quotient bits shift in
  logic [M-1:0]  divisor;
  logic [M:0]    rem;
  logic [M:0]    rem_next;
  logic          qbit;

  assign ready = (state != CALC);

  div_step #(.M(M)) u_step (
    .rem_in  (rem),
    .din     (work[N-1]),
    .divisor (divisor),
    .rem_out (rem_next),
    .qbit    (qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = (b == '0) ? DONE : CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (cnt == LAST) begin
          state_next = DONE;
        end else begin
          state_next = CALC;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // valid trails the DONE state by one cycle, so it is already clear on reset abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      work    <= '0;
      divisor <= '0;
      rem     <= '0;
      q       <= '0;
      r       <= '0;
      dbz     <= 1'b0;
      valid   <= 1'b0;
    end else begin
      valid <= (state == DONE);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            work    <= a;
            divisor <= b;
            rem     <= '0;
            cnt     <= '0;
            if (b == '0) begin
              q   <= '1;
              r   <= '0;
              dbz <= 1'b1;
            end
          end
        end
        CALC: begin
          work <= {work[N-2:0], qbit};
          rem  <= rem_next;
          if (cnt == LAST) begin
            cnt <= '0;
            q   <= {work[N-2:0], qbit};
            r   <= rem_next[M-1:0];
            dbz <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_8by4u.sv
// Self-checking bench for divider_8by4u: directed cases, start-ignore,
// reset abort, back-to-back and an exhaustive sweep against arithmetic.
module tb_divider_8by4u;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [3:0] b;
  logic       ready;
  logic [7:0] q;
  logic [3:0] r;
  logic       valid;
  logic       dbz;

  int ncmp;
  int nfail;

  divider_8by4u #(.N(8), .M(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .q     (q),
    .r     (r),
    .valid (valid),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division with the zero-divisor convention.
  function automatic logic [7:0] ref_q(input logic [7:0] x, input logic [3:0] y);
    if (y == 4'd0) return 8'hFF;
    return 8'(int'(x) / int'(y));
  endfunction

  function automatic logic [3:0] ref_r(input logic [7:0] x, input logic [3:0] y);
    if (y == 4'd0) return 4'h0;
    return 4'(int'(x) % int'(y));
  endfunction

  function automatic int ref_lat(input logic [3:0] y);
    return (y == 4'd0) ? 1 : 9;
  endfunction

  // Issue one start and wait for valid; lat counts edges after the start edge.
  task automatic run_op(input logic [7:0] ai, input logic [3:0] bi,
                        output int lat, output logic [7:0] qo,
                        output logic [3:0] ro, output logic dz);
    @(negedge clk);
    a = ai; b = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = k;
        break;
      end
    end
    qo = q; ro = r; dz = dbz;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    ncmp++; if (ready !== 1'b1) begin nfail++; $display("FAIL reset_ready got %b want 1", ready); end
    ncmp++; if (valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got %b want 0", valid); end
    ncmp++; if (q !== 8'h00) begin nfail++; $display("FAIL reset_q got %h want 00", q); end
    ncmp++; if (r !== 4'h0) begin nfail++; $display("FAIL reset_r got %h want 0", r); end
    ncmp++; if (dbz !== 1'b0) begin nfail++; $display("FAIL reset_dbz got %b want 0", dbz); end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [7:0] ta [4] = '{8'h7F, 8'hFF, 8'h05, 8'h3C};
    logic [3:0] tb_ [4] = '{4'h7, 4'hF, 4'h7, 4'h0};
    int lat; logic [7:0] qo; logic [3:0] ro; logic dz;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb_[i], lat, qo, ro, dz);
      ncmp++; if (lat !== ref_lat(tb_[i])) begin nfail++; $display("FAIL dir_latency a=%h b=%h got %0d want %0d", ta[i], tb_[i], lat, ref_lat(tb_[i])); end
      ncmp++; if (qo !== ref_q(ta[i], tb_[i])) begin nfail++; $display("FAIL dir_q a=%h b=%h got %h want %h", ta[i], tb_[i], qo, ref_q(ta[i], tb_[i])); end
      ncmp++; if (ro !== ref_r(ta[i], tb_[i])) begin nfail++; $display("FAIL dir_r a=%h b=%h got %h want %h", ta[i], tb_[i], ro, ref_r(ta[i], tb_[i])); end
      ncmp++; if (dz !== (tb_[i] == 4'h0)) begin nfail++; $display("FAIL dir_dbz a=%h b=%h got %b want %b", ta[i], tb_[i], dz, (tb_[i] == 4'h0)); end
      @(posedge clk); #1;
      ncmp++; if (valid !== 1'b0) begin nfail++; $display("FAIL dir_valid_pulse got %b want 0", valid); end
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    a = 8'h64; b = 4'h3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ncmp++; if (ready !== 1'b0) begin nfail++; $display("FAIL calc_ready got %b want 0", ready); end
    a = 8'h01; b = 4'h1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'h00; b = 4'h0;
    lat = -1;
    for (int k = 4; k <= 40; k++) begin
      @(posedge clk); #1;
      if (valid) begin lat = k; break; end
    end
    ncmp++; if (lat !== 9) begin nfail++; $display("FAIL ignore_latency got %0d want 9", lat); end
    ncmp++; if (q !== 8'h21) begin nfail++; $display("FAIL ignore_q got %h want 21", q); end
    ncmp++; if (r !== 4'h1) begin nfail++; $display("FAIL ignore_r got %h want 1", r); end
  endtask

  task automatic test_reset_abort;
    int seen; int lat; logic [7:0] qo; logic [3:0] ro; logic dz;
    @(negedge clk);
    a = 8'h64; b = 4'h3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ncmp++; if (ready !== 1'b1) begin nfail++; $display("FAIL abort_ready got %b want 1", ready); end
    ncmp++; if (q !== 8'h00) begin nfail++; $display("FAIL abort_q got %h want 00", q); end
    ncmp++; if (r !== 4'h0) begin nfail++; $display("FAIL abort_r got %h want 0", r); end
    seen = 0;
    for (int k = 0; k < 14; k++) begin
      if (valid) seen++;
      @(posedge clk); #1;
    end
    ncmp++; if (seen !== 0) begin nfail++; $display("FAIL abort_no_valid got %0d pulses want 0", seen); end
    run_op(8'h0E, 4'h2, lat, qo, ro, dz);
    ncmp++; if (qo !== 8'h07) begin nfail++; $display("FAIL abort_next_q got %h want 07", qo); end
    ncmp++; if (ro !== 4'h0) begin nfail++; $display("FAIL abort_next_r got %h want 0", ro); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a1, a2; logic [3:0] b1, b2; int lat;
    for (int n = 0; n < 4; n++) begin
      a1 = 8'($urandom_range(0, 255)); b1 = 4'($urandom_range(1, 15));
      a2 = 8'($urandom_range(0, 255)); b2 = 4'($urandom_range(1, 15));
      @(negedge clk);
      a = a1; b = b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      ncmp++; if (ready !== 1'b1) begin nfail++; $display("FAIL b2b_done_ready got %b want 1", ready); end
      a = a2; b = b2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ncmp++; if (valid !== 1'b1) begin nfail++; $display("FAIL b2b_first_valid got %b want 1", valid); end
      ncmp++; if ({q, r} !== {ref_q(a1, b1), ref_r(a1, b1)}) begin nfail++; $display("FAIL b2b_first a=%h b=%h got q=%h r=%h want q=%h r=%h", a1, b1, q, r, ref_q(a1, b1), ref_r(a1, b1)); end
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk); #1;
        if (valid) begin lat = k; break; end
      end
      ncmp++; if (lat !== 9) begin nfail++; $display("FAIL b2b_second_latency got %0d want 9", lat); end
      ncmp++; if ({q, r} !== {ref_q(a2, b2), ref_r(a2, b2)}) begin nfail++; $display("FAIL b2b_second a=%h b=%h got q=%h r=%h want q=%h r=%h", a2, b2, q, r, ref_q(a2, b2), ref_r(a2, b2)); end
    end
  endtask

  task automatic test_sweep;
    int lat; logic [7:0] qo; logic [3:0] ro; logic dz;
    for (int bi = 1; bi < 16; bi++) begin
      for (int ai = 0; ai < 256; ai++) begin
        run_op(8'(ai), 4'(bi), lat, qo, ro, dz);
        ncmp++;
        if (lat !== 9 || dz !== 1'b0 || (int'(qo) * bi + int'(ro)) !== ai || int'(ro) >= bi ||
            qo !== ref_q(8'(ai), 4'(bi)) || ro !== ref_r(8'(ai), 4'(bi))) begin
          nfail++;
          $display("FAIL sweep a=%h b=%h got q=%h r=%h dbz=%b lat=%0d want q=%h r=%h dbz=0 lat=9",
                   8'(ai), 4'(bi), qo, ro, dz, lat, ref_q(8'(ai), 4'(bi)), ref_r(8'(ai), 4'(bi)));
        end
      end
    end
    for (int n = 0; n < 8; n++) begin
      logic [7:0] ar;
      ar = 8'($urandom_range(0, 255));
      run_op(ar, 4'h0, lat, qo, ro, dz);
      ncmp++;
      if (lat !== 1 || qo !== 8'hFF || ro !== 4'h0 || dz !== 1'b1) begin
        nfail++;
        $display("FAIL dbz_rand a=%h got q=%h r=%h dbz=%b lat=%0d want q=ff r=0 dbz=1 lat=1", ar, qo, ro, dz, lat);
      end
    end
  endtask

  initial begin
    ncmp = 0;
    nfail = 0;
    test_reset;
    test_directed;
    test_ignore_start;
    test_reset_abort;
    test_back_to_back;
    test_sweep;
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

endmodule
